// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared state encoding, funct3 codes and access legality check
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Any address bit above the memory's byte span makes the access out of range.
    function automatic logic access_fault(
        input logic        we,
        input logic [2:0]  funct3,
        input logic [31:0] addr,
        input int          word_addr_w
    );
        logic illegal;
        logic misaligned;
        logic out_of_range;
        if (we) begin
            illegal = !(funct3 inside {F3_B, F3_H, F3_W});
        end else begin
            illegal = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        end
        misaligned = ((funct3 == F3_H || funct3 == F3_HU) && addr[0])
                   || ((funct3 == F3_W) && (addr[1:0] != 2'b00));
        out_of_range = (addr >> (word_addr_w + 2)) != 32'd0;
        return illegal | misaligned | out_of_range;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - request/response and Data_Memory signal bundle
interface mem_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault, mem_addr, mem_wd, mem_we
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault, mem_addr, mem_wd, mem_we
    );
endinterface

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - little-endian load lane extract/extend and store lane merge
module lsu_lane_align
    import mem_ctrl_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] load_word,
    input  logic [31:0] store_base,
    input  logic [31:0] store_wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ld_byte = load_word[{addr_lo, 3'b000} +: 8];
        ld_half = load_word[{addr_lo[1], 4'b0000} +: 16];
        case (funct3)
            F3_B:    load_data = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   load_data = {24'd0, ld_byte};
            F3_H:    load_data = {{16{ld_half[15]}}, ld_half};
            F3_HU:   load_data = {16'd0, ld_half};
            default: load_data = load_word;
        endcase
    end

    // Sub-word stores keep the untouched lanes of the word read back from memory.
    always_comb begin
        store_data = store_base;
        case (funct3)
            F3_B:    store_data[{addr_lo, 3'b000} +: 8]      = store_wdata[7:0];
            F3_H:    store_data[{addr_lo[1], 4'b0000} +: 16] = store_wdata[15:0];
            default: store_data = store_wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - load/store sequencer with read-modify-write for sub-word stores
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int WORD_ADDR_W = 16,
    parameter int DATA_W      = 32
) (
    input  logic              CLK,
    input  logic              RST,
    mem_access_ctrl_if.slave  bus
);

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [1:0]          addr_lo_q, addr_lo_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_fault_q, rsp_fault_d;
    logic [31:0]         mem_addr_q, mem_addr_d;

    logic                req_fault;
    logic [31:0]         load_data;
    logic [31:0]         store_data;

    lsu_lane_align u_align (
        .funct3      (funct3_q),
        .addr_lo     (addr_lo_q),
        .load_word   (bus.mem_rd),
        .store_base  (word_q),
        .store_wdata (wdata_q),
        .load_data   (load_data),
        .store_data  (store_data)
    );

    always_comb begin
        req_fault = access_fault(bus.req_we, bus.req_funct3, bus.req_addr, WORD_ADDR_W);
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        addr_lo_d   = addr_lo_q;
        wdata_d     = wdata_q;
        word_d      = word_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_fault_d = rsp_fault_q;
        mem_addr_d  = mem_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    we_d        = bus.req_we;
                    funct3_d    = bus.req_funct3;
                    addr_lo_d   = bus.req_addr[1:0];
                    wdata_d     = bus.req_wdata;
                    mem_addr_d  = {{(32-WORD_ADDR_W){1'b0}}, bus.req_addr[WORD_ADDR_W+1:2]};
                    rsp_rdata_d = '0;
                    rsp_fault_d = req_fault;
                    // Faults skip memory entirely; only sub-word stores need the read pass.
                    if (req_fault) begin
                        state_d = ST_RESP;
                    end else if (bus.req_we && (bus.req_funct3 == F3_W)) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                word_d = bus.mem_rd;
                if (we_q) begin
                    state_d = ST_WRITE;
                end else begin
                    rsp_rdata_d = load_data;
                    state_d     = ST_RESP;
                end
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            funct3_q    <= '0;
            addr_lo_q   <= '0;
            wdata_q     <= '0;
            word_q      <= '0;
            rsp_rdata_q <= '0;
            rsp_fault_q <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            addr_lo_q   <= addr_lo_d;
            wdata_q     <= wdata_d;
            word_q      <= word_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_fault_q <= rsp_fault_d;
            mem_addr_q  <= mem_addr_d;
        end
    end

    // Gating with RST lets a reset in the WRITE/RESP cycle cancel the write or response.
    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RESP) && !RST;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_fault = rsp_fault_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wd    = store_data;
    assign bus.mem_we    = (state_q == ST_WRITE) && !RST;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Load/store sequencer between the RISC-V core's memory stage and the word-addressed Data_Memory array (combinational read, write on posedge CLK).
- Accepts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests over a valid/ready handshake.
- Performs lane extraction with sign or zero extension.
- Performs read-modify-write sequencing for sub-word stores.
- Reports misaligned, illegal or out-of-range accesses as faults without touching memory.

Parameters:
WORD_ADDR_W, 16, word-index width of the memory (65536 words); byte-address bits above WORD_ADDR_W+1 must be zero.
DATA_W, 32, data word width; fixed at 32 (RV32).

Ports:
CLK  in  1  system clock; all state changes on posedge.
RST  in  1  synchronous reset, active-high.
req_valid  in  1  request present.
req_ready  out  1  controller can accept; high only in IDLE.
req_we  in  1  1 = store, 0 = load.
req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
req_addr  in  32  byte address.
req_wdata  in  32  store data; the low byte or halfword is used for SB/SH.
rsp_valid  out  1  one-cycle completion pulse.
rsp_rdata  out  32  extended load data; 0 for stores and faults.
rsp_fault  out  1  qualifies rsp_valid: access rejected.
mem_addr  out  32  word index to Data_Memory, equal to zero-extended req_addr[WORD_ADDR_W+1:2].
mem_wd  out  32  write data to Data_Memory.
mem_we  out  1  write enable to Data_Memory.
mem_rd  in  32  read data from Data_Memory (combinational).

Behaviour:
- States: IDLE, READ, WRITE, RESP.
- Reset (RST high at a posedge):
  - state goes to IDLE.
  - All capture registers, rsp_rdata, rsp_fault and mem_addr go to 0.
  - rsp_valid=0.
  - mem_we = (state==WRITE) && !RST, so a reset in the WRITE cycle suppresses the write.
- Acceptance:
  - Occurs in a cycle T with req_valid && req_ready.
  - The controller captures addr, funct3, we and wdata; later changes on req_* are ignored until the next IDLE.
- Fault check at acceptance:
  - Illegal funct3: load funct3 not in {000,001,010,100,101}; store funct3 not in {000,001,010}.
  - Misaligned: H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0.
  - Out of range: any of addr[31:WORD_ADDR_W+2] set.
  - A fault goes straight to RESP: rsp_valid=1 and rsp_fault=1 in T+1, with no mem_we.
- Load: IDLE → READ (T+1), then RESP (T+2).
  - In READ, mem_addr is driven and mem_rd is sampled at the end of the cycle.
  - Little-endian lanes: byte k = bits[8k+7:8k] selected by addr[1:0]; halfword selected by addr[1].
  - B/H sign-extend; BU/HU zero-extend.
- Word store: IDLE → WRITE (T+1) with mem_we=1 and mem_wd=wdata, then RESP (T+2).
- Sub-word store: IDLE → READ (T+1), then WRITE (T+2), then RESP (T+3).
  - READ latches mem_rd.
  - WRITE drives mem_wd = latched word with only the addressed lane(s) replaced.
- RESP:
  - rsp_valid=1 for exactly one cycle; no response backpressure.
  - Returns to IDLE; req_ready rises in the cycle after RESP.
- mem_we is high only in WRITE, for exactly one cycle per store.
- mem_addr holds the captured word index in all non-IDLE states.
- Throughput: at most one request per 3 cycles (loads, SW) or 4 cycles (SB/SH).
- A held req_valid after RESP is treated as a new request.
- RST in READ/WRITE/RESP aborts the access: no write, no rsp_valid, IDLE next cycle.

Decomposition:
- Shared package mem_ctrl_pkg:
  - state encoding: IDLE, READ, WRITE, RESP.
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - legality/alignment check function.
- Sub-module lsu_lane_align (purely combinational): load extract/extend and store lane merge, given funct3, addr[1:0], word and wdata.
- FSM and registers stay in mem_access_ctrl.

Test Plan:
1. Preload memory word 0x10 = 0x00000000. SW addr 0x40, wdata 0xDEADBEEF → mem_we=1 only in T+1, mem_addr=0x10, mem_wd=0xDEADBEEF; rsp_valid=1 at T+2, rsp_fault=0.
2. Word 0x10 = 0xDEADBEEF, issue loads:
   - LB 0x43 → 0xFFFFFFDE
   - LBU 0x43 → 0x000000DE
   - LH 0x42 → 0xFFFFDEAD
   - LHU 0x40 → 0x0000BEEF
   - LW 0x40 → 0xDEADBEEF
   - each rsp_valid at T+2.
3. Word 0x10 = 0xDEADBEEF, SB 0x41, wdata 0x123456AA → READ at T+1, WRITE at T+2 with mem_wd=0xDEADAAEF; SH 0x42, wdata 0x7777 → mem_wd=0x7777AAEF; rsp_valid at T+3.
4. Faults → rsp_valid=1, rsp_fault=1 at T+1, rsp_rdata=0, mem_we never asserted:
   - LW 0x42
   - SH 0x41
   - LB 0x00040000
   - load funct3=011
   - SB with funct3=100
5. RST raised during the WRITE cycle of an SB → mem_we=0 that cycle, word unchanged, no rsp_valid, req_ready=1 the following cycle.
6. req_valid held high across two LW requests (0x40, 0x44) → req_ready low in READ/RESP; second accept in cycle T+3; rsp pulses at T+2 and T+5.
